iserdes_word_align: RTL and testbench
=====================================

Name: iserdes_word_align

Overview:
- Receive-side companion to the 10:1 DDR serializer path in the timing-generator link.
- Takes raw 10-bit parallel words from a 1:10 deserializer whose word boundary is arbitrary, and finds the bit rotation that reproduces a known training word.
- Outputs boundary-aligned words and supervises lock on a continuously-running training lane, typically the link clock lane.
- Sits in the clk_div domain directly behind the deserializer primitive pair.

Parameters:
- TRAIN_PATTERN, 10'b1111100000, training word expected on the lane once aligned. Its 10 rotations must be distinct.
- LOCK_COUNT, 16, consecutive matches required to declare lock (range 2..255).
- ERR_LIMIT, 4, consecutive mismatches while locked that cause loss of lock (range 1..15).
- MAX_SWEEPS, 4, full 10-offset sweeps without any match before align_err is raised (range 1..15).

Ports:
- clk  in  1  word clock (divided clock of the serial link); all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  10  raw deserialized word; bit 0 is the earliest received bit.
- realign  in  1  single-cycle request to drop lock and restart the search.
- data_out  out  10  aligned word.
- data_valid  out  1  high while locked; qualifies data_out.
- locked  out  1  alignment achieved.
- bit_offset  out  4  current rotation, 0..9.
- align_err  out  1  sticky flag: no match found within MAX_SWEEPS sweeps.

Behaviour:
- Reset: data_out=0, data_valid=0, locked=0, bit_offset=0, align_err=0. State=SEARCH; the previous-word register, match counter, error counter and sweep counter are all 0.
- Window: raw_prev <= data_in every cycle. window[19:0] = {data_in, raw_prev}. The candidate word is cand = window[bit_offset+9 : bit_offset], selected combinationally.
- Datapath: data_out <= cand every cycle regardless of state. Latency is 1 clk from data_in to data_out.
- Match: match = (cand == TRAIN_PATTERN), evaluated every cycle.
- State SEARCH:
  - match → go to VERIFY with match_cnt=1.
  - Otherwise bit_offset increments, wrapping 9→0.
  - Each wrap increments the sweep counter. When it reaches MAX_SWEEPS, align_err goes high and the search continues.
  - align_err clears only on rst or realign.
- State VERIFY:
  - match → match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 and data_valid=1 on the same edge.
  - Mismatch → go to SEARCH with bit_offset+1 (same wrap rule), match_cnt=0.
- State LOCKED:
  - bit_offset is frozen.
  - match → err_cnt=0.
  - Mismatch → err_cnt++. When err_cnt reaches ERR_LIMIT, go to SEARCH: locked=0, data_valid=0, err_cnt=0, bit_offset unchanged, sweep counter=0.
  - Fewer than ERR_LIMIT consecutive mismatches leave locked high.
- realign:
  - Takes effect in any state with priority over the match logic.
  - Next state is SEARCH, with locked=0, data_valid=0, align_err=0 and all counters 0.
  - bit_offset advances by 1, wrapping 9→0, so that a re-search starts at a new rotation.
- Simultaneous events:
  - rst beats realign; realign beats match or mismatch.
  - A mismatch on the same cycle that match_cnt would reach LOCK_COUNT returns to SEARCH; lock is not declared.
- Counters saturate and never wrap: match_cnt at LOCK_COUNT, sweep counter at MAX_SWEEPS.

Test Plan:
- Stream of the repeating 10-bit pattern 1111100000 delayed by 3 bits, after rst → bit_offset settles at 3 and locked rises within 4+LOCK_COUNT cycles. Then data_out==10'b1111100000 with data_valid=1 every cycle.
- Repeat for each delay 0..9 → final bit_offset equals the delay. align_err=0 throughout.
- Data_in constant 10'h000 for 4×10+2 cycles → align_err=1 and locked=0. Then realign → align_err=0 on the next cycle.
- Locked at offset 3, inject 3 consecutive corrupted words then clean pattern → locked stays 1. Inject 4 consecutive corrupted words → locked=0 on the edge after the 4th, then re-locks at offset 3.
- While in VERIFY with match_cnt=10, corrupt one word → returns to SEARCH, bit_offset=4, and locked stays 0 until a full re-search completes.
- Assert rst while locked with realign high on the same cycle → all outputs 0 on the next cycle and state is SEARCH.

Source files
------------

// File: rtl/iserdes_word_align.sv
// Word aligner for a 1:10 deserializer: sweeps the 10 bit rotations until the
// training word is seen LOCK_COUNT times in a row, then holds the rotation and supervises lock.
module iserdes_word_align #(
    parameter logic [9:0] TRAIN_PATTERN = 10'b1111100000,
    parameter int         LOCK_COUNT    = 16,
    parameter int         ERR_LIMIT     = 4,
    parameter int         MAX_SWEEPS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] data_in,
    input  logic       realign,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       align_err
);

    // state   | meaning
    // SEARCH  | stepping bit_offset one rotation per cycle looking for a match
    // VERIFY  | candidate rotation found, counting consecutive matches
    // LOCKED  | rotation frozen, counting consecutive mismatches
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] LOCK_FULL  = 8'(LOCK_COUNT);
    localparam logic [3:0] ERR_LAST   = 4'(ERR_LIMIT - 1);
    localparam logic [3:0] SWEEP_LAST = 4'(MAX_SWEEPS - 1);
    localparam logic [3:0] SWEEP_FULL = 4'(MAX_SWEEPS);

    state_t      state;
    logic [9:0]  raw_prev;
    logic [7:0]  match_cnt;
    logic [3:0]  err_cnt;
    logic [3:0]  sweep_cnt;
    logic [19:0] window;
    logic [19:0] shifted;
    logic [9:0]  cand;
    logic        match;
    logic [3:0]  next_offset;

    always_comb begin
        window      = {data_in, raw_prev};
        shifted     = window >> bit_offset;
        cand        = shifted[9:0];
        match       = (cand == TRAIN_PATTERN);
        next_offset = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            raw_prev   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            bit_offset <= '0;
            align_err  <= 1'b0;
            match_cnt  <= '0;
            err_cnt    <= '0;
            sweep_cnt  <= '0;
        end else begin
            raw_prev <= data_in;
            data_out <= cand;
            if (realign) begin
                state      <= SEARCH;
                data_valid <= 1'b0;
                locked     <= 1'b0;
                align_err  <= 1'b0;
                match_cnt  <= '0;
                err_cnt    <= '0;
                sweep_cnt  <= '0;
                bit_offset <= next_offset;
            end else begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            state     <= VERIFY;
                            match_cnt <= 8'd1;
                        end else begin
                            bit_offset <= next_offset;
                            if (bit_offset == 4'd9 && sweep_cnt != SWEEP_FULL) begin
                                sweep_cnt <= sweep_cnt + 4'd1;
                                if (sweep_cnt == SWEEP_LAST)
                                    align_err <= 1'b1;
                            end
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            if (match_cnt >= LOCK_LAST) begin
                                state      <= LOCKED;
                                match_cnt  <= LOCK_FULL;
                                locked     <= 1'b1;
                                data_valid <= 1'b1;
                                err_cnt    <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            state      <= SEARCH;
                            match_cnt  <= '0;
                            bit_offset <= next_offset;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            err_cnt <= '0;
                        end else if (err_cnt == ERR_LAST) begin
                            // offset stays put: a re-search starts from the last good rotation
                            state      <= SEARCH;
                            locked     <= 1'b0;
                            data_valid <= 1'b0;
                            err_cnt    <= '0;
                            match_cnt  <= '0;
                            sweep_cnt  <= '0;
                        end else begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iserdes_word_align.sv
// Directed bench for iserdes_word_align: per-delay lock table plus
// hand-timed sequences for error tolerance, verify abort, sweep timeout and realign/reset.
module tb_iserdes_word_align;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] data_in;
    logic       realign;
    logic [9:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [3:0] bit_offset;
    logic       align_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [9:0] PAT = 10'b1111100000;
    localparam logic [9:0] W3  = 10'b1100000111;

    iserdes_word_align dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .realign    (realign),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .bit_offset (bit_offset),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] word;
        int         exp_offset;
        logic [9:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_with(input logic [9:0] w);
        rst     = 1'b1;
        realign = 1'b0;
        data_in = w;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int budget);
        int i = 0;
        while (!locked && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(locked), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10'b1111100000, 0, PAT};
        vecs[1] = '{10'b1111000001, 1, PAT};
        vecs[2] = '{10'b1110000011, 2, PAT};
        vecs[3] = '{10'b1100000111, 3, PAT};
        vecs[4] = '{10'b1000001111, 4, PAT};
        vecs[5] = '{10'b0000011111, 5, PAT};
        vecs[6] = '{10'b0000111110, 6, PAT};
        vecs[7] = '{10'b0001111100, 7, PAT};
        vecs[8] = '{10'b0011111000, 8, PAT};
        vecs[9] = '{10'b0111110000, 9, PAT};

        // reset state
        reset_with(10'h2A5);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_offset", int'(bit_offset), 0);
        check("rst_align_err", int'(align_err), 0);

        // lock on every rotation
        for (int v = 0; v < 10; v++) begin
            reset_with(vecs[v].word);
            wait_lock($sformatf("lock_d%0d", v), 60);
            check($sformatf("offset_d%0d", v), int'(bit_offset), vecs[v].exp_offset);
            for (int c = 0; c < 3; c++) begin
                tick();
                check($sformatf("data_d%0d", v), int'(data_out), int'(vecs[v].exp_data));
                check($sformatf("valid_d%0d", v), int'(data_valid), 1);
            end
            check($sformatf("aerr_d%0d", v), int'(align_err), 0);
        end

        // exact lock edge for delay 3: 3 search cycles + 16 matches
        reset_with(W3);
        repeat (18) tick();
        check("lock_edge18", int'(locked), 0);
        tick();
        check("lock_edge19", int'(locked), 1);
        check("lock_edge19_off", int'(bit_offset), 3);

        // 3 corrupted words tolerated (bit 5 only hits the following cycle's candidate)
        data_in = W3 ^ 10'b0000100000;
        repeat (3) begin
            tick();
            check("err3_locked", int'(locked), 1);
        end
        data_in = W3;
        repeat (3) begin
            tick();
            check("err3_recover", int'(locked), 1);
        end

        // 4 corrupted words drop lock one edge after the 4th
        data_in = W3 ^ 10'b0000100000;
        repeat (4) tick();
        check("err4_still_locked", int'(locked), 1);
        data_in = W3;
        tick();
        check("err4_unlocked", int'(locked), 0);
        check("err4_valid", int'(data_valid), 0);
        check("err4_offset", int'(bit_offset), 3);
        wait_lock("err4_relock", 30);
        check("err4_relock_off", int'(bit_offset), 3);

        // mismatch in VERIFY at match_cnt=10
        reset_with(W3);
        repeat (13) tick();
        data_in = W3 ^ 10'b0000000001;
        tick();
        data_in = W3;
        check("verify_abort_off", int'(bit_offset), 4);
        check("verify_abort_lock", int'(locked), 0);
        repeat (24) tick();
        check("verify_relock_edge38", int'(locked), 0);
        tick();
        check("verify_relock_edge39", int'(locked), 1);
        check("verify_relock_off", int'(bit_offset), 3);

        // realign while locked steps to next rotation
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("realign_locked", int'(locked), 0);
        check("realign_valid", int'(data_valid), 0);
        check("realign_off", int'(bit_offset), 4);

        // mismatch when match_cnt would reach LOCK_COUNT
        reset_with(W3);
        repeat (18) tick();
        data_in = W3 ^ 10'b0000000001;
        tick();
        data_in = W3;
        check("last_verify_lock", int'(locked), 0);
        check("last_verify_off", int'(bit_offset), 4);

        // sweep timeout on constant zero input
        reset_with(10'h000);
        repeat (39) tick();
        check("sweep_edge39", int'(align_err), 0);
        tick();
        check("sweep_edge40", int'(align_err), 1);
        repeat (2) tick();
        check("sweep_edge42", int'(align_err), 1);
        check("sweep_locked", int'(locked), 0);
        check("sweep_off", int'(bit_offset), 2);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("sweep_realign_err", int'(align_err), 0);
        check("sweep_realign_off", int'(bit_offset), 3);

        // rst and realign together while locked
        reset_with(W3);
        wait_lock("pre_rst_lock", 30);
        rst     = 1'b1;
        realign = 1'b1;
        tick();
        rst     = 1'b0;
        realign = 1'b0;
        check("rstre_data_out", int'(data_out), 0);
        check("rstre_valid", int'(data_valid), 0);
        check("rstre_locked", int'(locked), 0);
        check("rstre_offset", int'(bit_offset), 0);
        check("rstre_align_err", int'(align_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
